// File: rtl/engine_read_write_response_kernel.sv
// Return path of the read/write engine: in-order request tracking, line element extraction and packet rebuild.
// Optional macro ENGINE_READ_WRITE_RESPONSE_SIGN_EXT_EN enables per-entry sign extension of 1B/2B elements.
module engine_read_write_response_kernel #(
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 32,
  parameter int LINE_W     = 512,
  parameter int TAG_DEPTH  = 16,
  parameter int ID_W       = 4,
  localparam int OFF_W     = $clog2(LINE_W / 8),
  localparam int CNT_W     = $clog2(TAG_DEPTH + 1)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          req_valid_in,
  output logic                          req_ready_out,
  input  logic [OFF_W-1:0]              req_byte_offset_in,
  input  logic [1:0]                    req_size_in,
  input  logic                          req_signed_in,
  input  logic [ID_W-1:0]               req_id_in,
  input  logic [NUM_FIELDS*FIELD_W-1:0] req_fields_in,
  input  logic [NUM_FIELDS*2-1:0]       req_states_in,
  input  logic                          rsp_valid_in,
  output logic                          rsp_ready_out,
  input  logic [LINE_W-1:0]             rsp_data_in,
  input  logic [ID_W-1:0]               rsp_id_in,
  output logic                          out_valid_out,
  input  logic                          out_ready_in,
  output logic [NUM_FIELDS*FIELD_W-1:0] out_fields_out,
  output logic [NUM_FIELDS*2-1:0]       out_states_out,
  output logic [CNT_W-1:0]              outstanding_out,
  output logic                          id_error_out
);

  localparam int AW         = $clog2(TAG_DEPTH);
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int HI_FW      = (NUM_FIELDS - 1) * FIELD_W;
  localparam int HI_SW      = (NUM_FIELDS - 1) * 2;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Field 0 and state 0 of the incoming packet are replaced on the way out, so they are never stored.
  logic [OFF_W-1:0] r_off_mem    [TAG_DEPTH];
  logic [1:0]       r_size_mem   [TAG_DEPTH];
  logic [ID_W-1:0]  r_id_mem     [TAG_DEPTH];
  logic [HI_FW-1:0] r_fields_mem [TAG_DEPTH];
  logic [HI_SW-1:0] r_states_mem [TAG_DEPTH];
`ifdef ENGINE_READ_WRITE_RESPONSE_SIGN_EXT_EN
  logic             r_sgn_mem    [TAG_DEPTH];
`endif

  logic [AW:0]                   r_wr_ptr;
  logic [AW:0]                   r_rd_ptr;
  logic                          r_out_valid;
  logic [NUM_FIELDS*FIELD_W-1:0] r_out_fields;
  logic [NUM_FIELDS*2-1:0]       r_out_states;
  logic                          r_id_error;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [AW-1:0]         w_wr_idx;
  logic [AW-1:0]         w_rd_idx;
  logic [OFF_W-1:0]      w_off;
  logic [1:0]            w_size;
  logic [OFF_W+2:0]      w_shamt;
  logic [31:0]           w_raw;
  logic [FIELD_W-1:0]    w_elem;
  logic [HI_FW-1:0]      w_hi_fields;
  logic [HI_SW-1:0]      w_hi_states;
`ifdef ENGINE_READ_WRITE_RESPONSE_SIGN_EXT_EN
  logic                  w_last_byte;
  logic [FIELD_W+1:0]    w_unused_in;
  assign w_unused_in = {req_fields_in[FIELD_W-1:0], req_states_in[1:0]};
`else
  logic [FIELD_W+2:0]    w_unused_in;
  assign w_unused_in = {req_signed_in, req_fields_in[FIELD_W-1:0], req_states_in[1:0]};
`endif

  // The extra pointer MSB separates full (MSBs differ, index equal) from empty (pointers equal).
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);

  assign req_ready_out = !w_full;
  assign rsp_ready_out = !w_empty && (!r_out_valid || out_ready_in);
  assign w_push        = req_valid_in && !w_full;
  assign w_pop         = rsp_valid_in && rsp_ready_out;

  assign w_off       = r_off_mem[w_rd_idx];
  assign w_size      = r_size_mem[w_rd_idx];
  assign w_hi_fields = r_fields_mem[w_rd_idx];
  assign w_hi_states = r_states_mem[w_rd_idx];

  // Zero fill from the right shift makes bytes past the top of the line read as 0.
  assign w_shamt = {w_off, 3'b000};
  assign w_raw   = 32'(rsp_data_in >> w_shamt);

`ifdef ENGINE_READ_WRITE_RESPONSE_SIGN_EXT_EN
  assign w_last_byte = (w_off == OFF_W'(LINE_BYTES - 1));
`endif

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_elem = '0;
    case (w_size)
      2'd0:    w_elem[7:0]  = w_raw[7:0];
      2'd1:    w_elem[15:0] = w_raw[15:0];
      default: w_elem[31:0] = w_raw;
    endcase
`ifdef ENGINE_READ_WRITE_RESPONSE_SIGN_EXT_EN
    // A 2B element truncated at the line end has one valid byte, so it extends from bit 7.
    if (r_sgn_mem[w_rd_idx] && !w_size[1]) begin
      if (w_size == 2'd0 || w_last_byte) begin
        if (w_raw[7]) w_elem[FIELD_W-1:8] = '1;
      end else if (w_raw[15]) begin
        w_elem[FIELD_W-1:16] = '1;
      end
    end
`endif
  end

  // NOTE: the tracking storage is not reset; an entry is only read after the pointers say it was written.
  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_off_mem[w_wr_idx]    <= req_byte_offset_in;
      r_size_mem[w_wr_idx]   <= req_size_in;
      r_id_mem[w_wr_idx]     <= req_id_in;
      r_fields_mem[w_wr_idx] <= req_fields_in[NUM_FIELDS*FIELD_W-1:FIELD_W];
      r_states_mem[w_wr_idx] <= req_states_in[NUM_FIELDS*2-1:2];
`ifdef ENGINE_READ_WRITE_RESPONSE_SIGN_EXT_EN
      r_sgn_mem[w_wr_idx]    <= req_signed_in;
`endif
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_out_valid  <= 1'b0;
      r_out_fields <= '0;
      r_out_states <= '0;
      r_id_error   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PTR_ONE;
        r_out_valid  <= 1'b1;
        r_out_fields <= {w_hi_fields, w_elem};
        // Out state 0 carries the address field state (stored state 1).
        r_out_states <= {w_hi_states, w_hi_states[1:0]};
        if (rsp_id_in != r_id_mem[w_rd_idx]) r_id_error <= 1'b1;
      end else if (out_ready_in) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid_out   = r_out_valid;
  assign out_fields_out  = r_out_fields;
  assign out_states_out  = r_out_states;
  assign id_error_out    = r_id_error;
  assign outstanding_out = CNT_W'(r_wr_ptr - r_rd_ptr);

endmodule

// File: doc/engine_read_write_response_kernel.md
# engine_read_write_response_kernel

Return-path companion to the read/write engine's request kernel. The request kernel issues shifted address requests and carries the original engine packet alongside. This block:
- records per-request metadata in an in-order tracking FIFO;
- accepts the matching memory line responses;
- extracts the addressed element from each line;
- rebuilds the engine packet with the fetched value in field 0.

It sits between the memory response channel and the engine's downstream packet port.

## Interface
- NUM_FIELDS, 4, engine packet fields
- FIELD_W, 32, bits per field (max element size)
- LINE_W, 512, memory response line width (power of two, ≥ FIELD_W)
- TAG_DEPTH, 16, tracking FIFO entries (power of two)
- ID_W, 4, buffer id width
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- req_valid_in / req_ready_out  in/out  1  metadata push handshake (one per issued read)
- req_byte_offset_in  in  clog2(LINE_W/8)  byte lane of element within line
- req_size_in  in  2  element size: 0=1B, 1=2B, 2=4B, 3=reserved (treated as 4B)
- req_signed_in  in  1  element is signed (used only when the macro is enabled)
- req_id_in  in  ID_W  expected response buffer id
- req_fields_in  in  NUM_FIELDS*FIELD_W  original packet fields
- req_states_in  in  NUM_FIELDS*2  original field states
- rsp_valid_in / rsp_ready_out  in/out  1  memory response handshake
- rsp_data_in  in  LINE_W  response line
- rsp_id_in  in  ID_W  response buffer id
- out_valid_out / out_ready_in  out/in  1  rebuilt packet handshake
- out_fields_out  out  NUM_FIELDS*FIELD_W  rebuilt fields
- out_states_out  out  NUM_FIELDS*2  rebuilt states
- outstanding_out  out  clog2(TAG_DEPTH+1)  FIFO occupancy
- id_error_out  out  1  sticky id-mismatch flag

## Operation
Tracking FIFO:
- req_ready_out = !full.
- A push occurs when req_valid_in && req_ready_out.
- When full, req_ready_out is 0 even if a pop occurs in the same cycle.

Response acceptance:
- rsp_ready_out = !empty && (!out_valid_out || out_ready_in).
- Empty is sampled from the registered FIFO state, so an entry pushed in cycle N is poppable no earlier than cycle N+1.
- A response arriving with the FIFO empty stalls; it is never dropped.

Pop (rsp_valid_in && rsp_ready_out):
- Raw element = rsp_data_in >> (byte_offset*8), masked to the size's byte count.
- Bytes beyond the top of the line read as 0, e.g. offset LINE_W/8−1 with 4B size gives 1 valid byte.
- out field 0 = extended element. Out fields 1..NUM_FIELDS−1 = stored fields 1..NUM_FIELDS−1.
- out state 0 = stored state 1 (address field state). Other states are copied unchanged.
- If rsp_id_in ≠ stored id, id_error_out sets and stays set until reset. The packet is still delivered.

Output register:
- Single entry. out_valid_out sets on pop.
- out_valid_out clears on out_ready_in without a new pop in the same cycle.
- Data is held stable while out_valid_out && !out_ready_in.

outstanding_out:
- +1 on push, −1 on pop, unchanged on simultaneous push and pop.

## Timing
- Reset values: out_valid_out=0, out_fields_out=0, out_states_out=0 (SEQUENCE_INVALID), outstanding_out=0, id_error_out=0.
- Pointers are cleared by reset, so req_ready_out=1 and rsp_ready_out=0 after reset.
- Latency: response handshake in cycle N gives out_valid_out high in cycle N+1.
- Throughput: one packet per cycle when out_ready_in is held high.
- Reset asserted mid-operation discards all FIFO entries and any held output immediately (asynchronous).
- Pointers wrap modulo TAG_DEPTH. Full and empty are distinguished by an extra pointer MSB.

## Configuration
- ENGINE_READ_WRITE_RESPONSE_SIGN_EXT_EN
  - Defined: req_signed_in is stored per entry. Signed 1B/2B elements are sign-extended to FIELD_W.
  - Undefined: req_signed_in is not stored, and all elements are zero-extended.

## Test plan
- Reset, then push 1 entry (offset 4, 4B, id 3) and send a line with bytes 4..7 = 0xDEADBEEF, id 3 -> out field0=0xDEADBEEF one cycle after the handshake, id_error_out=0, outstanding goes 1→0.
- Push 16 entries -> req_ready_out=0 and outstanding_out=16. A 17th push is held. Pop one in the same cycle as the held push -> the 17th push is still not accepted that cycle and is accepted the next.
- Offset 63, 2B, line byte63=0x80, macro enabled with signed=1 -> field0=0xFFFFFF80. Macro disabled -> field0=0x00000080.
- Hold out_ready_in=0 with 2 responses pending -> out data stable, rsp_ready_out=0 after the first pop. Release -> two packets in order on consecutive cycles.
- Response with id 5 vs stored id 2 -> packet delivered, id_error_out=1 and it stays 1 across later matching responses.
- Assert ap_rst_n low with 3 entries outstanding and out_valid_out high -> all outputs at reset values the same cycle. The next response stalls (rsp_ready_out=0).
